sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Responder for the memory-stage requests (mem_read / mem_write) that instruction decode issues for MEMORY_TYPE instructions.
- Accepts one 32-bit word access per request and performs it as two sequential 16-bit external SRAM accesses.
- Drives a ready signal; the pipeline stays frozen while ready=0.
- Sits between the MEM stage and the board SRAM pins.

Parameters:
- DATA_WIDTH, 32, CPU word width.
- SRAM_DATA_WIDTH, 16, external SRAM data bus width (DATA_WIDTH/2).
- SRAM_ADDR_WIDTH, 18, external SRAM address width.
- BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1, extra cycles each half-access is held (0 or more).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  word read request.
- mem_write  in  1  word write request.
- address  in  32  CPU byte address (ALU result).
- write_data  in  32  store data (Rm value).
- ready  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- read_data  out  32  last completed read word.
- sram_addr  out  SRAM_ADDR_WIDTH  SRAM half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out (top level builds the inout).
- sram_dq_in  in  16  data from SRAM.
- sram_we_n  out  1  active-low SRAM write enable.

Behaviour:
- Reset (async, any state): state=IDLE, wait counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1. An access in flight is aborted with no completion pulse.
- ready is combinational: (state==IDLE && !(mem_read||mem_write)) || state==DONE.
- States: IDLE, LOW, HIGH, DONE.
- IDLE:
  - Request seen: latch offset = (address - BASE_ADDR) mod 2^32, the op, and write_data; go to LOW.
  - No request: stay in IDLE.
- LOW:
  - sram_addr = {offset[SRAM_ADDR_WIDTH:2], 1'b0}; offset bits [1:0] are ignored, so unaligned addresses access the enclosing aligned word.
  - Held WAIT_CYCLES+1 cycles, counted by the wait counter; then go to HIGH.
- HIGH: same as LOW with low address bit = 1 and the upper half-word; held WAIT_CYCLES+1 cycles; then go to DONE.
- DONE: one cycle with ready=1; unconditionally return to IDLE. Request inputs are ignored in this cycle. The pipeline advances on this edge.
- Write:
  - LOW phase: sram_dq_out=write_data[15:0], sram_dq_oe=1, sram_we_n=0.
  - HIGH phase: same with write_data[31:16].
  - sram_we_n returns to 1 in DONE and IDLE.
- Read:
  - sram_dq_oe=0 and sram_we_n=1 throughout.
  - sram_dq_in is registered into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
  - read_data is valid from DONE and holds until the next read's capture. Writes never modify read_data.
- Latency: the ready-low window is 1 + 2*(WAIT_CYCLES+1) cycles, which is 5 at default.
- Request held with both mem_read and mem_write high: treated as a read; sram_we_n stays 1.
- Requester holds address, write_data, mem_read and mem_write stable while ready=0. Changes mid-access are ignored because they are latched in IDLE.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. There is no idle bubble beyond that cycle.
- Offset wrap: addresses below BASE_ADDR wrap modulo 2^32 and are truncated to the SRAM address width. No error signal.
- sram_addr holds its last value in IDLE and DONE.

Decomposition:
- Defines.v:
  - state encodings (SRAM_IDLE, SRAM_LOW, SRAM_HIGH, SRAM_DONE)
  - SRAM_BASE_ADDR
  - SRAM data and address width macros
  - reuse of ENABLE/DISABLE
- One sub-module: sram_wait_counter. It is a loadable down-counter with a zero flag, cleared on rst, reloaded at each phase entry.

Test Plan:
- Idle, no request for 10 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- mem_write=1, address=1024, write_data=0x12345678 ->
  - ready=0 for exactly 5 cycles, then 1 for one cycle;
  - sram_addr=0 with dq 0x5678 for 2 cycles, then sram_addr=1 with dq 0x1234 for 2 cycles;
  - sram_we_n=0 only during those 4 cycles.
- SRAM model preloaded: word 4 = 0xBEEF, word 5 = 0xCAFE; mem_read=1, address=1032 -> sram_addr 4 then 5; read_data=0xCAFEBEEF in DONE; ready pulses 1 once.
- mem_read=1 and mem_write=1 at address 1024, after the write above -> read performed, sram_we_n never 0, read_data=0x12345678.
- rst asserted mid-write after the LOW phase -> same cycle: sram_we_n=1, sram_dq_oe=0, read_data=0; after release, state IDLE and ready=!(mem_read||mem_write).
- Back-to-back write to 1028 (0xAAAA5555) then read of 1028 -> second access starts in the IDLE cycle after DONE; read_data=0xAAAA5555; total 12 cycles.

Source files
------------

// File: rtl/sram_mem_controller_pkg.sv
// Shared encodings and widths for the word-to-halfword SRAM controller.
package sram_mem_controller_pkg;
  localparam int          CPU_DATA_W     = 32;
  localparam int          SRAM_DATA_W    = 16;
  localparam int          SRAM_ADDR_W    = 18;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
  localparam logic        ENABLE         = 1'b1;
  localparam logic        DISABLE        = 1'b0;

  typedef enum logic [1:0] {
    SRAM_IDLE,
    SRAM_LOW,
    SRAM_HIGH,
    SRAM_DONE
  } sram_state_t;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter; zero flags the final cycle of a half-access phase.
module sram_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage responder: one 32-bit access split into two 16-bit SRAM accesses,
// holding ready low until the word completes.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int DATA_WIDTH      = CPU_DATA_W,
  parameter int SRAM_DATA_WIDTH = SRAM_DATA_W,
  parameter int SRAM_ADDR_WIDTH = SRAM_ADDR_W,
  parameter int BASE_ADDR       = int'(SRAM_BASE_ADDR),
  parameter int WAIT_CYCLES     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [31:0]                address,
  input  logic [DATA_WIDTH-1:0]      write_data,
  output logic                       ready,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_we_n
);
  localparam int          CW        = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

  sram_state_t state, next_state;

  logic                       req, accept, cnt_zero, phase_load;
  logic [31:0]                diff;
  logic [SRAM_ADDR_WIDTH-2:0] offset_q, cur_off;
  logic [DATA_WIDTH-1:0]      wdata_q, cur_wd;
  logic                       is_wr_q, cur_wr;
  logic [SRAM_ADDR_WIDTH-1:0] addr_d;
  logic [SRAM_DATA_WIDTH-1:0] dq_d;
  logic                       oe_d, we_n_d;
  logic                       unused_diff;

  assign req    = mem_read | mem_write;
  assign accept = (state == SRAM_IDLE) && req;
  assign ready  = ((state == SRAM_IDLE) && !req) || (state == SRAM_DONE);

  // Word offset into SRAM; byte-lane bits and bits beyond the SRAM range drop out.
  assign diff        = address - 32'(BASE_ADDR);
  assign unused_diff = ^{diff[31:SRAM_ADDR_WIDTH+1], diff[1:0]};

  // Output registers load from next_state, so the request is used directly on the accept edge.
  assign cur_off = accept ? diff[SRAM_ADDR_WIDTH:2]       : offset_q;
  assign cur_wd  = accept ? write_data                    : wdata_q;
  assign cur_wr  = accept ? (mem_write & ~mem_read)       : is_wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
    end else if (accept) begin
      offset_q <= cur_off;
      wdata_q  <= cur_wd;
      is_wr_q  <= cur_wr;
    end
  end

  assign phase_load = ((state == SRAM_IDLE) && (next_state == SRAM_LOW)) ||
                      ((state == SRAM_LOW)  && (next_state == SRAM_HIGH));

  sram_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (phase_load),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SRAM_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SRAM_IDLE: if (req)      next_state = SRAM_LOW;
      SRAM_LOW:  if (cnt_zero) next_state = SRAM_HIGH;
      SRAM_HIGH: if (cnt_zero) next_state = SRAM_DONE;
      default:                 next_state = SRAM_IDLE;
    endcase
  end

  always_comb begin
    addr_d = sram_addr;
    dq_d   = sram_dq_out;
    oe_d   = DISABLE;
    we_n_d = 1'b1;
    case (next_state)
      SRAM_LOW: begin
        addr_d = {cur_off, 1'b0};
        if (cur_wr) begin
          dq_d   = cur_wd[SRAM_DATA_WIDTH-1:0];
          oe_d   = ENABLE;
          we_n_d = 1'b0;
        end
      end
      SRAM_HIGH: begin
        addr_d = {cur_off, 1'b1};
        if (cur_wr) begin
          dq_d   = cur_wd[DATA_WIDTH-1:SRAM_DATA_WIDTH];
          oe_d   = ENABLE;
          we_n_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      sram_addr   <= addr_d;
      sram_dq_out <= dq_d;
      sram_dq_oe  <= oe_d;
      sram_we_n   <= we_n_d;
    end
  end

  // Capture each half on the last cycle of its phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (cnt_zero && !is_wr_q) begin
      if (state == SRAM_LOW)  read_data[SRAM_DATA_WIDTH-1:0]          <= sram_dq_in;
      if (state == SRAM_HIGH) read_data[DATA_WIDTH-1:SRAM_DATA_WIDTH] <= sram_dq_in;
    end
  end
endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized bench for sram_mem_controller with a cycle-timeline reference model.
module tb_sram_mem_controller;
  localparam int W     = 1;
  localparam int NDATA = 2 * (W + 1);
  localparam int DONE_K = NDATA + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int vectors = 0, miscompares = 0;
  int cyc = 0;

  logic [15:0] sram      [0:262143];
  logic [15:0] model_mem [0:262143];

  sram_mem_controller #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .ready(ready),
    .read_data(read_data), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: k counts cycles since acceptance (0 = idle / accepting cycle).
  int          k = 0;
  logic [31:0] exp_rd = '0;
  logic [17:0] last_addr = '0, m_half = '0;
  logic [31:0] m_wd = '0;
  logic        m_wr = 1'b0;

  always @(negedge clk) begin
    logic [17:0] a;
    logic [15:0] d;
    logic        hi;
    if (rst) begin
      check("rst_ready", ready, !(mem_read || mem_write));
      check("rst_we_n", sram_we_n, 1'b1);
      check("rst_oe", sram_dq_oe, 1'b0);
      check("rst_addr", sram_addr, 18'd0);
      check("rst_rdata", read_data, 32'd0);
      k = 0; exp_rd = '0; last_addr = '0;
    end else if (k == 0) begin
      check("idle_ready", ready, !(mem_read || mem_write));
      check("idle_we_n", sram_we_n, 1'b1);
      check("idle_oe", sram_dq_oe, 1'b0);
      check("idle_addr", sram_addr, last_addr);
      check("idle_rdata", read_data, exp_rd);
      if (mem_read || mem_write) begin
        m_half = 18'(((address - 32'd1024) >> 2) * 2);
        m_wr   = mem_write && !mem_read;
        m_wd   = write_data;
        k = 1;
      end
    end else if (k <= NDATA) begin
      hi = (k > W + 1);
      a  = m_half + 18'(hi);
      d  = hi ? m_wd[31:16] : m_wd[15:0];
      check("busy_ready", ready, 1'b0);
      check("busy_addr", sram_addr, a);
      check("busy_we_n", sram_we_n, !m_wr);
      check("busy_oe", sram_dq_oe, m_wr);
      if (m_wr) check("busy_dq", sram_dq_out, d);
      check("busy_rdata", read_data, exp_rd);
      if (m_wr) model_mem[a] = d;
      else if (k == W + 1) exp_rd[15:0]  = model_mem[a];
      else if (k == NDATA) exp_rd[31:16] = model_mem[a];
      last_addr = a;
      k++;
    end else begin
      check("done_ready", ready, 1'b1);
      check("done_we_n", sram_we_n, 1'b1);
      check("done_oe", sram_dq_oe, 1'b0);
      check("done_addr", sram_addr, last_addr);
      check("done_rdata", read_data, exp_rd);
      k = 0;
    end
  end

  // Present a request in the coming IDLE cycle and hold it until ready rises.
  task automatic access(input logic rd, input logic wr, input logic [31:0] ad,
                        input logic [31:0] wd, output int lowcnt, output int start);
    bit got = 0;
    @(posedge clk); #2;
    mem_read = rd; mem_write = wr; address = ad; write_data = wd;
    start = cyc; lowcnt = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1; else lowcnt++;
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #2;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int lc, st, st0;
    for (int i = 0; i < 262144; i++) begin
      sram[i] = '0; model_mem[i] = '0;
    end
    sram[4] = 16'hBEEF; model_mem[4] = 16'hBEEF;
    sram[5] = 16'hCAFE; model_mem[5] = 16'hCAFE;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pin_idle_ready", ready, 1'b1);
    check("pin_idle_rdata", read_data, 32'd0);

    access(1'b0, 1'b1, 32'd1024, 32'h12345678, lc, st);
    check("pin_wr_lowcnt", lc, 5);
    access(1'b1, 1'b0, 32'd1032, 32'h0, lc, st);
    check("pin_rd_lowcnt", lc, 5);
    check("pin_rd_data", read_data, 32'hCAFEBEEF);
    access(1'b1, 1'b1, 32'd1024, 32'hFFFF0000, lc, st);
    check("pin_both_data", read_data, 32'h12345678);
    idle(2);

    // Abort a write during its HIGH phase.
    @(posedge clk); #2;
    mem_write = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1; mem_write = 1'b0;
    #1;
    check("pin_abort_we_n", sram_we_n, 1'b1);
    check("pin_abort_oe", sram_dq_oe, 1'b0);
    check("pin_abort_rdata", read_data, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    idle(2);

    access(1'b0, 1'b1, 32'd1028, 32'hAAAA5555, lc, st0);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lc, st);
    check("pin_b2b_cycles", cyc - st0 + 1, 12);
    check("pin_b2b_data", read_data, 32'hAAAA5555);
    idle(1);

    for (int n = 0; n < 80; n++) begin
      logic rd, wr;
      logic [31:0] ad;
      int sel = $urandom_range(0, 2);
      rd = (sel != 1); wr = (sel != 0);
      if ($urandom_range(0, 7) == 0) ad = 32'd1024 - $urandom_range(1, 16);
      else                           ad = 32'd1024 + $urandom_range(0, 63);
      access(rd, wr, ad, $urandom, lc, st);
      check("rand_lowcnt", lc, 5);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
